// File: rtl/spi_peripheral.sv
// SPI mode-0 responder, MSB first, active-low chip select.
// Pins are synchronized into clk_in; all SPI activity is edge-event driven.
module spi_peripheral #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid_out,
    output logic                  frame_error_out,
    output logic                  busy_out,
    input  logic                  chip_clk_in,
    input  logic                  chip_sel_in,
    input  logic                  chip_data_in,
    output logic                  chip_data_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;
    logic                   copi_hist_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   copi_s;

    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   cs_fall_q;
    logic                   cs_rise_q;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   cipo_q, cipo_d;
    logic                   ovr_q, ovr_d;

    logic [DATA_WIDTH-1:0]  rx_word;
    logic [DATA_WIDTH-1:0]  tx_shifted;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    // copi history is aligned with the sclk event that samples it
    assign rx_word    = {rx_shift_q[DATA_WIDTH-2:0], copi_hist_q};
    assign tx_shifted = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};

    // Pin synchronizers, history flops and registered edge events
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            copi_hist_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], chip_clk_in};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], chip_sel_in};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], chip_data_in};
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
            copi_hist_q <= copi_s;
            sclk_rise_q <= sclk_s & ~sclk_hist_q;
            sclk_fall_q <= ~sclk_s & sclk_hist_q;
            cs_fall_q   <= ~cs_s & cs_hist_q;
            cs_rise_q   <= cs_s & ~cs_hist_q;
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            cipo_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            cipo_q      <= cipo_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state logic; a cs fall restarts the frame from any state
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        cipo_d      = cipo_q;
        ovr_d       = ovr_q;

        if (cs_fall_q) begin
            tx_shift_d = tx_data_in;
            cipo_d     = tx_data_in[DATA_WIDTH-1];
            rx_shift_d = '0;
            bit_cnt_d  = '0;
            busy_d     = 1'b1;
            ovr_d      = 1'b0;
            state_d    = ACTIVE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    cipo_d = 1'b0;
                end
                ACTIVE: begin
                    if (cs_rise_q) begin
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                        cipo_d      = 1'b0;
                        state_d     = IDLE;
                    end else if (sclk_rise_q) begin
                        rx_shift_d = rx_word;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            state_d    = DONE;
                        end
                    end else if (sclk_fall_q && bit_cnt_q != '0) begin
                        tx_shift_d = tx_shifted;
                        cipo_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end
                DONE: begin
                    if (cs_rise_q) begin
                        busy_d  = 1'b0;
                        cipo_d  = 1'b0;
                        state_d = IDLE;
                    end else if (sclk_rise_q) begin
                        if (!ovr_q) begin
                            frame_err_d = 1'b1;
                            ovr_d       = 1'b1;
                        end
                    end else if (sclk_fall_q) begin
                        tx_shift_d = tx_shifted;
                        cipo_d     = 1'b0;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    cipo_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data_out     = rx_data_q;
    assign rx_valid_out    = rx_valid_q;
    assign frame_error_out = frame_err_q;
    assign busy_out        = busy_q;
    assign chip_data_out   = cipo_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed frames plus random frames
// checked against a per-frame behavioural model.
module tb_spi_peripheral;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          copi = 1'b0;
    logic          cipo;

    int            checks = 0;
    int            failures = 0;
    int            val_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] vwords[$];
    logic [DW-1:0] last_rx = '0;

    spi_peripheral #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .tx_data_in      (tx_data),
        .rx_data_out     (rx_data),
        .rx_valid_out    (rx_valid),
        .frame_error_out (frame_err),
        .busy_out        (busy),
        .chip_clk_in     (sclk),
        .chip_sel_in     (cs),
        .chip_data_in    (copi),
        .chip_data_out   (cipo)
    );

    always #5 clk = ~clk;

    // Pulse monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            val_cnt++;
            vwords.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One controller frame of n bits (first bit = bits[n-1]).
    // rst_bit >= 0 asserts reset asynchronously before that bit.
    task automatic spi_frame(input logic [DW-1:0] tx, input logic [63:0] bits,
                             input int n, input int half, input int gap,
                             input int rst_bit, input bit do_check,
                             input string tag);
        logic [63:0] got = '0;
        logic [63:0] exp = '0;
        int vb = val_cnt;
        int eb = err_cnt;
        for (int k = 0; k < n; k++)
            exp[n-1-k] = (k < DW) ? tx[DW-1-k] : 1'b0;
        tx_data = tx;
        cs = 1'b0;
        for (int k = 0; k < n; k++) begin
            copi = bits[n-1-k];
            repeat (half) @(negedge clk);
            if (k == rst_bit) begin
                check({tag, " busy_pre_rst"}, busy, 1);
                #3 rst_n = 1'b0;
                #1;
                check({tag, " rst_busy"}, busy, 0);
                check({tag, " rst_cipo"}, cipo, 0);
                check({tag, " rst_rx"}, rx_data, 0);
                check({tag, " rst_pulses"}, {rx_valid, frame_err}, 0);
                sclk = 1'b0;
                cs = 1'b1;
                copi = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                last_rx = '0;
                repeat (3) @(negedge clk);
                return;
            end
            got[n-1-k] = cipo;
            sclk = 1'b1;
            if (k == 0) begin
                check({tag, " busy_mid"}, busy, 1);
                tx_data = $urandom;
            end
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        cs = 1'b1;
        copi = 1'b0;
        if (n >= DW) last_rx = bits[n-1 -: DW];
        check({tag, " cipo_bits"}, got, exp);
        repeat (gap) @(negedge clk);
        if (do_check) begin
            repeat (6) @(negedge clk);
            #1;
            check({tag, " valid_cnt"}, val_cnt - vb, (n >= DW) ? 1 : 0);
            check({tag, " err_cnt"}, err_cnt - eb, (n != DW) ? 1 : 0);
            if (n >= DW && val_cnt > vb)
                check({tag, " rx_word"}, vwords[vb], last_rx);
            check({tag, " rx_data"}, rx_data, last_rx);
            check({tag, " busy_end"}, busy, 0);
            check({tag, " cipo_idle"}, cipo, 0);
        end
    endtask

    initial begin
        int vb;
        int eb;
        int n;
        int sel;
        logic [63:0] bits;

        // Reset held while pins toggle
        repeat (2) @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk;
            copi = i[0];
            repeat (2) @(negedge clk);
        end
        check("rst_rx", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cipo", cipo, 0);
        sclk = 1'b0;
        cs = 1'b1;
        copi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cipo", cipo, 0);
        check("post_rst_pulses", val_cnt + err_cnt, 0);

        spi_frame(32'hA5C3_0F81, 64'hDEAD_BEEF, 32, 5, 0, -1, 1'b1, "nominal");
        spi_frame(32'h1234_5678, 64'h000A_BCDE, 20, 6, 0, -1, 1'b1, "short");
        spi_frame(32'h8765_4321, {30'd0, 32'hCAFE_F00D, 2'b10}, 34, 5, 0, -1,
                  1'b1, "overrun");

        vb = val_cnt;
        eb = err_cnt;
        spi_frame(32'h0F0F_00FF, 64'h0000_0001, 32, 5, 4, -1, 1'b0, "b2b_a");
        spi_frame(32'hF00D_1234, 64'hFFFF_FFFF, 32, 5, 0, -1, 1'b1, "b2b_b");
        check("b2b valid_total", val_cnt - vb, 2);
        check("b2b err_total", err_cnt - eb, 0);
        if (val_cnt - vb == 2) begin
            check("b2b word0", vwords[vb], 32'h0000_0001);
            check("b2b word1", vwords[vb+1], 32'hFFFF_FFFF);
        end

        spi_frame(32'h1357_9BDF, 64'h2468_ACE0, 32, 5, 0, 10, 1'b0, "midrst");
        check("midrst rx_zero", rx_data, 0);
        spi_frame(32'h0BAD_CAFE, 64'h7654_3210, 32, 5, 0, -1, 1'b1, "after_rst");

        for (int r = 0; r < 8; r++) begin
            sel = $urandom_range(0, 2);
            n = (sel == 0) ? DW :
                (sel == 1) ? $urandom_range(1, DW - 1) :
                             $urandom_range(DW + 1, DW + 2);
            bits = {$urandom, $urandom};
            spi_frame($urandom, bits, n, $urandom_range(5, 8), 0, -1, 1'b1,
                      $sformatf("rand%0d_n%0d", r, n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
